// File: rtl/eth_axis_if.sv
// AXI-Stream beat bundle shared by the RX (slave) and TX (master) sides of the packet FIFO.
interface eth_axis_if #(
  parameter int DATA_W = 64
) ();
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward packet FIFO for the 10G RX->TX path: only whole, clean frames
// reach TX; errored or overflowing frames are dropped whole and counted per cause.
module eth_pkt_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 9,
  parameter int DROP_BAD   = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk156,
  input  logic             eth_rst_n,
  eth_axis_if.slave        s_axis,
  eth_axis_if.master       m_axis,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad,
  output logic [CNT_W-1:0] frames_ovf,
  output logic [7:0]       debug
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int ENT_W  = DATA_W + KEEP_W + 2;

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, RECV = 2'd2, DROP = 2'd3} wstate_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n;
  wstate_t    wstate;
  ptr_t       wr_ptr, wr_commit, rd_ptr, fe_ptr;
  logic       full, commit_empty, beat, wr_en, fetch, load_out;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] ent_p1, ent_p2;
  logic             vld_p1, vld_p2;

  // Reset asserts asynchronously and releases two clk156 edges later.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // The full test uses rd_ptr, which only advances on a TX handshake, so beats
  // already copied into the read pipeline still occupy RAM capacity.
  assign full         = (ptr_t'(wr_ptr - rd_ptr) == PTR_DEPTH);
  assign commit_empty = (rd_ptr == wr_commit);
  assign beat         = s_axis.tvalid;
  assign wr_en        = beat && !full && (wstate == IDLE || wstate == RECV);
  assign s_axis.tready = 1'b1;

  // ---- stage p0: write FSM ----
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      wstate     <= SYNC;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      frames_ok  <= '0;
      frames_bad <= '0;
      frames_ovf <= '0;
    end else begin
      unique case (wstate)
        SYNC: if (!beat || s_axis.tlast) wstate <= IDLE;
        IDLE, RECV: begin
          if (beat) begin
            if (full) begin
              wr_ptr     <= wr_commit;
              frames_ovf <= sat_inc(frames_ovf);
              wstate     <= s_axis.tlast ? IDLE : DROP;
            end else if (!s_axis.tlast) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              wstate <= RECV;
            end else if (s_axis.tuser && (DROP_BAD != 0)) begin
              wr_ptr     <= wr_commit;
              frames_bad <= sat_inc(frames_bad);
              wstate     <= IDLE;
            end else begin
              wr_ptr    <= wr_ptr + PTR_ONE;
              wr_commit <= wr_ptr + PTR_ONE;
              frames_ok <= sat_inc(frames_ok);
              wstate    <= IDLE;
            end
          end
        end
        DROP: if (beat && s_axis.tlast) wstate <= IDLE;
        default: wstate <= SYNC;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <=
        {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  // ---- stage p1: RAM prefetch of committed entries ----
  assign load_out = vld_p1 && (!vld_p2 || m_axis.tready);
  assign fetch    = (fe_ptr != wr_commit) && (!vld_p1 || load_out);

  always_ff @(posedge clk156) begin
    if (fetch) ent_p1 <= mem[fe_ptr[DEPTH_LOG2-1:0]];
  end

  // ---- stage p2: AXIS output register ----
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      fe_ptr <= '0;
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ent_p2 <= '0;
    end else begin
      if (fetch) fe_ptr <= fe_ptr + PTR_ONE;
      if (fetch)         vld_p1 <= 1'b1;
      else if (load_out) vld_p1 <= 1'b0;
      if (load_out) begin
        vld_p2 <= 1'b1;
        ent_p2 <= ent_p1;
      end else if (m_axis.tready) begin
        vld_p2 <= 1'b0;
      end
      if (vld_p2 && m_axis.tready) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign m_axis.tvalid = vld_p2;
  assign m_axis.tdata  = ent_p2[DATA_W-1:0];
  assign m_axis.tkeep  = ent_p2[DATA_W +: KEEP_W];
  assign m_axis.tlast  = ent_p2[ENT_W-2];
  assign m_axis.tuser  = (DROP_BAD != 0) ? 1'b0 : ent_p2[ENT_W-1];

  assign debug = {wstate, full, commit_empty, vld_p2, m_axis.tready,
                  s_axis.tvalid, s_axis.tlast};
endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Bench for eth_pkt_fifo: a small-depth dropping instance (A) and a deep forwarding
// instance (B), each checked against a queue of expected TX beats.
module tb_eth_pkt_fifo;
  typedef logic [73:0] ent_t;  // {tuser, tlast, tkeep, tdata}

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_tv = 1'b0, b_tv = 1'b0, a_rdy, b_rdy;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0, s_tuser = 1'b0;
  logic [2:0]  a_ok, a_bad, a_ovf;
  logic [31:0] b_ok, b_bad, b_ovf;
  logic [7:0]  a_dbg, b_dbg;

  eth_axis_if #(.DATA_W(64)) a_s (), a_m (), b_s (), b_m ();

  assign a_s.tvalid = a_tv;    assign b_s.tvalid = b_tv;
  assign a_s.tdata  = s_tdata; assign b_s.tdata  = s_tdata;
  assign a_s.tkeep  = s_tkeep; assign b_s.tkeep  = s_tkeep;
  assign a_s.tlast  = s_tlast; assign b_s.tlast  = s_tlast;
  assign a_s.tuser  = s_tuser; assign b_s.tuser  = s_tuser;
  assign a_m.tready = a_rdy;   assign b_m.tready = b_rdy;

  eth_pkt_fifo #(.DATA_W(64), .DEPTH_LOG2(4), .DROP_BAD(1), .CNT_W(3)) dut_a (
    .clk156(clk), .eth_rst_n(rst_n), .s_axis(a_s), .m_axis(a_m),
    .frames_ok(a_ok), .frames_bad(a_bad), .frames_ovf(a_ovf), .debug(a_dbg));

  eth_pkt_fifo #(.DATA_W(64), .DEPTH_LOG2(9), .DROP_BAD(0), .CNT_W(32)) dut_b (
    .clk156(clk), .eth_rst_n(rst_n), .s_axis(b_s), .m_axis(b_m),
    .frames_ok(b_ok), .frames_bad(b_bad), .frames_ovf(b_ovf), .debug(b_dbg));

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  ent_t qa[$], qb[$];
  int   a_beats = 0, b_beats = 0, a_first = 0, fid = 0, last_cyc = 0;
  logic a_seen = 1'b0, a_stall = 1'b0, b_stall = 1'b0;
  ent_t a_cur, a_prev, a_exp, b_cur, b_prev, b_exp;

  always @(negedge rst_n) begin
    a_stall = 1'b0; b_stall = 1'b0; a_seen = 1'b0;
    a_beats = 0; b_beats = 0;
  end

  always @(negedge clk) begin
    a_cur = {a_m.tuser, a_m.tlast, a_m.tkeep, a_m.tdata};
    if (a_stall) begin
      chk("a_hold_valid", a_m.tvalid, 1);
      chk("a_hold_data", a_cur, a_prev);
    end
    if (a_m.tvalid && !a_seen) begin a_seen = 1'b1; a_first = cyc; end
    if (a_m.tvalid && a_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_beat", qa.size(), 1);
      else begin a_exp = qa.pop_front(); chk("a_beat", a_cur, a_exp); end
      a_beats++;
    end
    a_stall = a_m.tvalid && !a_rdy;
    a_prev  = a_cur;
  end

  always @(negedge clk) begin
    b_cur = {b_m.tuser, b_m.tlast, b_m.tkeep, b_m.tdata};
    if (b_stall) begin
      chk("b_hold_valid", b_m.tvalid, 1);
      chk("b_hold_data", b_cur, b_prev);
    end
    if (b_m.tvalid && b_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_beat", qb.size(), 1);
      else begin b_exp = qb.pop_front(); chk("b_beat", b_cur, b_exp); end
      b_beats++;
    end
    b_stall = b_m.tvalid && !b_rdy;
    b_prev  = b_cur;
  end

  // tready modes: 0 = held low, 1 = held high, 2 = random 50%
  int a_mode = 1, b_mode = 1;
  initial begin
    a_rdy = 1'b1; b_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_rdy = (a_mode == 2) ? 1'($urandom_range(0, 1)) : (a_mode == 1);
      b_rdy = (b_mode == 2) ? 1'($urandom_range(0, 1)) : (b_mode == 1);
    end
  end

  function automatic ent_t mk(input int id, input int i, input int len,
                              input logic user, input int nb);
    logic       last;
    logic [7:0] keep;
    logic [63:0] d;
    last = (i == len - 1);
    keep = last ? (8'hFF >> (8 - nb)) : 8'hFF;
    d    = {id[15:0], i[15:0], $urandom()};
    return {last & user, last, keep, d};
  endfunction

  task automatic drive(input logic va, input logic vb, input ent_t e);
    a_tv = va; b_tv = vb;
    {s_tuser, s_tlast, s_tkeep, s_tdata} = e;
    @(posedge clk); #1;
    a_tv = 1'b0; b_tv = 1'b0;
  endtask

  task automatic send_frame(input logic va, input logic vb, input int len, input logic user,
                            input int nb, input logic ea, input logic eb);
    ent_t e;
    for (int i = 0; i < len; i++) begin
      e = mk(fid, i, len, user, nb);
      if (ea) qa.push_back(e);
      if (eb) qb.push_back(e);
      drive(va, vb, e);
    end
    fid++;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
    idle(4);
    chk("drain_a_left", qa.size(), 0);
    chk("drain_b_left", qb.size(), 0);
  endtask

  task automatic do_reset();
    a_tv = 1'b0; b_tv = 1'b0;
    #1 rst_n = 1'b0;
    qa.delete(); qb.delete();
    idle(3);
    rst_n = 1'b1;
    idle(4);
  endtask

  int t1_last, b_sent;
  ent_t e;

  initial begin
    // reset state
    #1 rst_n = 1'b0;
    idle(3);
    chk("rst_a_tvalid", a_m.tvalid, 0);
    chk("rst_b_tvalid", b_m.tvalid, 0);
    chk("rst_a_ok", a_ok, 0);
    chk("rst_a_state", a_dbg[7:6], 0);
    chk("rst_b_tdata", b_m.tdata, 0);
    rst_n = 1'b1;
    idle(4);
    chk("post_rst_state", a_dbg[7:6], 1);
    chk("s_tready", {a_s.tready, b_s.tready}, 2'b11);

    // three back-to-back 8-beat frames
    send_frame(1, 0, 8, 0, 8, 1, 0);
    t1_last = last_cyc;
    send_frame(1, 0, 8, 0, 8, 1, 0);
    send_frame(1, 0, 8, 0, 8, 1, 0);
    drain(200);
    chk("t1_latency", a_first - t1_last, 2);
    chk("t1_ok", a_ok, 3);
    chk("t1_beats", a_beats, 24);
    chk("t1_commit_empty", a_dbg[4], 1);

    // errored frame then good frame: A drops it, B forwards it with tuser
    do_reset();
    send_frame(1, 1, 5, 1, 3, 0, 1);
    send_frame(1, 1, 4, 0, 8, 1, 1);
    drain(200);
    chk("t2_a_ok", a_ok, 1);
    chk("t2_a_bad", a_bad, 1);
    chk("t2_a_beats", a_beats, 4);
    chk("t2_b_ok", b_ok, 2);
    chk("t2_b_bad", b_bad, 0);
    chk("t2_b_beats", b_beats, 9);

    // overflow of a second 10-beat frame while TX is stalled
    do_reset();
    a_mode = 0;
    idle(2);
    send_frame(1, 0, 10, 0, 8, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, mk(fid, i, 10, 0, 8));
      if (i == 5) begin chk("t3_ovf_beat6", a_ovf, 0); chk("t3_full_beat6", a_dbg[5], 1); end
      if (i == 6) begin chk("t3_ovf_beat7", a_ovf, 1); chk("t3_drop_state", a_dbg[7:6], 3); end
    end
    fid++;
    idle(10);
    chk("t3_ovf", a_ovf, 1);
    chk("t3_ok", a_ok, 1);
    chk("t3_idle", a_dbg[7:6], 1);
    chk("t3_stalled_valid", a_m.tvalid, 1);
    chk("t3_no_beats", a_beats, 0);
    a_mode = 1;
    drain(200);
    chk("t3_beats", a_beats, 10);
    send_frame(1, 0, 6, 0, 5, 1, 0);
    drain(200);
    chk("t3_beats2", a_beats, 16);
    chk("t3_ok2", a_ok, 2);

    // frame longer than the buffer
    do_reset();
    send_frame(1, 0, 20, 0, 8, 0, 0);
    idle(10);
    chk("t4_ovf", a_ovf, 1);
    chk("t4_ok", a_ok, 0);
    chk("t4_state", a_dbg[7:6], 1);
    chk("t4_beats", a_beats, 0);

    // 3-bit counter saturates
    do_reset();
    for (int f = 0; f < 9; f++) send_frame(1, 0, 1, 0, 2, 1, 0);
    drain(200);
    chk("t5_ok_sat", a_ok, 7);
    chk("t5_beats", a_beats, 9);

    // random tready, 200 mixed frames into B
    do_reset();
    b_mode = 2;
    b_sent = 0;
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(1, 16);
      b_sent += len;
      send_frame(0, 1, len, ($urandom_range(0, 7) == 0), $urandom_range(1, 8), 0, 1);
      idle($urandom_range(8, 20));
    end
    drain(20000);
    b_mode = 1;
    chk("t6_b_ok", b_ok, 200);
    chk("t6_b_ovf", b_ovf, 0);
    chk("t6_b_beats", b_beats, b_sent);
    chk("t6_b_state", b_dbg[7:6], 1);

    // reset in the middle of a frame
    do_reset();
    a_mode = 0;
    idle(2);
    send_frame(1, 0, 3, 0, 8, 1, 0);
    idle(5);
    chk("t7_pre_valid", a_m.tvalid, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, mk(fid, i, 6, 0, 8));
    e = mk(fid, 3, 6, 0, 8);
    a_tv = 1'b1;
    {s_tuser, s_tlast, s_tkeep, s_tdata} = e;
    #1 rst_n = 1'b0;
    qa.delete();
    #1;
    chk("t7_rst_valid", a_m.tvalid, 0);
    chk("t7_rst_ok", a_ok, 0);
    chk("t7_rst_tdata", a_m.tdata, 0);
    a_mode = 1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    a_tv = 1'b0;
    drive(1, 0, mk(fid, 4, 6, 0, 8));
    chk("t7_sync_state", a_dbg[7:6], 0);
    drive(1, 0, mk(fid, 5, 6, 0, 8));
    fid++;
    chk("t7_idle_state", a_dbg[7:6], 1);
    send_frame(1, 0, 4, 0, 6, 1, 0);
    drain(200);
    chk("t7_ok", a_ok, 1);
    chk("t7_beats", a_beats, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/eth_pkt_fifo.md
Name: eth_pkt_fifo

Overview:
- Parametrised store-and-forward packet FIFO between a 10G MAC RX AXI-Stream and the TX AXI-Stream, in the clk156 domain.
- Replaces the plain word FIFO on the RX→TX path.
- Only complete frames are forwarded. Errored frames (tuser=1) and frames that overflow the buffer are dropped whole, so TX never sees a truncated frame.
- Per-cause drop counters are provided.

Parameters:
- DATA_W, 64: stream data width in bits; multiple of 8. KEEP_W = DATA_W/8 is derived internally.
- DEPTH_LOG2, 9: buffer depth is 2**DEPTH_LOG2 beats.
- DROP_BAD, 1: 1 = drop frames whose last beat has tuser=1. 0 = keep them and forward tuser on the last beat.
- CNT_W, 32: statistics counter width.

Ports:
- clk156  in  1  sole clock.
- eth_rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  RX beat valid. There is no tready: the MAC cannot be stalled.
- s_axis_tdata  in  DATA_W  RX data.
- s_axis_tkeep  in  KEEP_W  RX byte enables.
- s_axis_tlast  in  1  RX end of frame.
- s_axis_tuser  in  1  RX frame error; meaningful on the last beat only.
- m_axis_tready  in  1  TX ready.
- m_axis_tvalid  out  1  TX valid.
- m_axis_tdata  out  DATA_W  TX data.
- m_axis_tkeep  out  KEEP_W  TX byte enables.
- m_axis_tlast  out  1  TX end of frame.
- m_axis_tuser  out  1  TX error. Constant 0 when DROP_BAD=1.
- frames_ok  out  CNT_W  count of committed frames.
- frames_bad  out  CNT_W  count of frames dropped for tuser.
- frames_ovf  out  CNT_W  count of frames dropped for overflow.
- debug  out  8  {wstate[1:0], full, commit_empty, m_axis_tvalid, m_axis_tready, s_axis_tvalid, s_axis_tlast}.

Behaviour:
- Storage: DEPTH-entry RAM of {tuser, tlast, tkeep, tdata} with one-cycle registered read.
- Pointers, each DEPTH_LOG2+1 bits and wrapping naturally:
  - wr_ptr: speculative write pointer.
  - wr_commit: committed write pointer.
  - rd_ptr: read pointer.
- full = (wr_ptr - rd_ptr == DEPTH). commit_empty = (rd_ptr == wr_commit).
- Reset (async assert, sync deassert inside the block):
  - all pointers, counters and m_axis_* outputs go to 0;
  - wstate = SYNC.
- Write FSM, which samples a beat on every cycle with s_axis_tvalid=1:
  - SYNC: discards beats. Goes to IDLE after a tlast beat, or on any cycle with tvalid=0. The MAC guarantees tvalid stays contiguous within a frame, so this stops a frame caught mid-flight at reset from being stored.
  - IDLE/RECV, beat arrives and full=0: write the beat at wr_ptr and increment wr_ptr. A non-last beat moves the FSM to RECV. A last beat is handled as follows:
    - tuser=1 and DROP_BAD=1: wr_ptr <= wr_commit, frames_bad++, go to IDLE.
    - otherwise: wr_commit <= wr_ptr+1, frames_ok++, go to IDLE.
  - IDLE/RECV, beat arrives and full=1: the beat is not written; wr_ptr <= wr_commit; frames_ovf++.
    - If the beat is the last beat, go to IDLE.
    - Otherwise go to DROP.
    - A frame longer than DEPTH beats is therefore always dropped as overflow.
  - DROP: discards beats. Returns to IDLE on the tlast beat. No counter changes.
- Counters saturate at all-ones and do not wrap.
- Read side:
  - The output register loads when (!m_axis_tvalid || m_axis_tready) and the RAM holds a valid prefetched entry below wr_commit.
  - A prefetch stage keeps full throughput: one beat per cycle while tready=1 and committed data remains.
  - Latency: a last beat sampled at cycle N gives the frame's first beat on m_axis_tvalid no earlier than N+2, when the FIFO was previously empty.
- AXIS rules:
  - m_axis_tdata, tkeep, tlast and tuser stay stable while tvalid=1 and tready=0.
  - tvalid never drops before the handshake.
- Simultaneous events:
  - A read and a write in the same cycle are both performed.
  - full uses the registered rd_ptr (conservative by one cycle).
  - A rewind of wr_ptr never moves it below wr_commit, so committed data is never disturbed.
- Reset mid-operation: all buffered frames are discarded, and the output goes to tvalid=0 immediately on assertion.

Test Plan:
- Reset, then 3 back-to-back 8-beat frames with tuser=0 and tready=1 → 24 beats out, byte-identical, tlast on beats 8/16/24, frames_ok=3, first m_axis_tvalid 2 cycles after the first tlast.
- One frame with tuser=1 on its last beat, followed by a good 4-beat frame, DROP_BAD=1 → only the 4-beat frame is output, frames_bad=1, frames_ok=1. Repeated with DROP_BAD=0 → both frames output, m_axis_tuser=1 on the first frame's last beat.
- DEPTH_LOG2=4, tready=0, frames of 10 then 10 beats → first committed; second overflows at its 7th beat and is dropped, frames_ovf=1. Then tready=1 → exactly 10 beats out. A following 6-beat frame is accepted.
- Single 20-beat frame with DEPTH_LOG2=4 → dropped, frames_ovf=1, nothing output, FSM back in IDLE after its tlast.
- Random tready (50%) over 200 mixed-length frames (1–16 beats, tkeep partial on last beat) → scoreboard matches, no tvalid drop before handshake, data stable under stall.
- eth_rst_n asserted at beat 3 of a 6-beat frame and released mid-frame → outputs go to 0 and the remaining beats are discarded in SYNC. The next full frame passes and frames_ok=1 counts only it.
